mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
Sequencer that sits directly in front of and behind the 4:1 select mux (s0, s1, a, b, c, d -> y). It drives the mux select lines round-robin through channels a, b, c, d. After each select change it waits a settle time, then samples y. It packs the four samples into a 4-bit frame and hands the frame downstream over a valid/ready handshake. The mux stays combinational; this block supplies all of its select timing.

Parameters:
SETTLE_CYCLES, 2, clock cycles between a select change and its settle window ending; legal range 1..15.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  single-cycle request for one scan; sampled only in IDLE.
cont  input  1  continuous mode; when high at the end of a frame, the next scan begins immediately.
s0  output  1  mux select LSB, registered.
s1  output  1  mux select MSB, registered.
y  input  1  mux output, sampled synchronously.
frame  output  4  last published frame; bit0=a, bit1=b, bit2=c, bit3=d.
frame_valid  output  1  frame holds unconsumed data.
frame_ready  input  1  downstream accepts frame on an edge where frame_valid && frame_ready.
busy  output  1  high in any state other than IDLE.
overrun  output  1  sticky; set when a completed frame is dropped.
clr_ovr  input  1  clears overrun (takes priority over a same-cycle set).

Behaviour:
- Reset (rst=1 at an edge, any state, mid-scan included) sets:
  - state to IDLE, ch to 0, settle counter to 0, shadow to 0.
  - s0=0, s1=0, frame=0, frame_valid=0, busy=0, overrun=0.
  - A partially gathered frame is discarded.
- Channel encoding: {s1,s0}=ch. ch0->a (00), ch1->b (01), ch2->c (10), ch3->d (11).
- IDLE:
  - start=1 -> SETTLE, with ch=0 and {s1,s0}=00 loaded on the same edge.
  - start while busy is ignored.
- SETTLE: stays for exactly SETTLE_CYCLES cycles, counting down, then -> SAMPLE.
- SAMPLE (one cycle): shadow[ch] <= y on the exiting edge.
  - If ch<3: ch++, {s1,s0} updated on the same edge, -> SETTLE.
  - If ch==3: -> PUBLISH.
  - y is therefore sampled SETTLE_CYCLES+1 edges after the select changed.
- PUBLISH (one cycle), on its exiting edge:
  - If frame_valid==0, or frame_valid && frame_ready: frame <= shadow, frame_valid <= 1.
  - Otherwise: frame unchanged, overrun <= 1, new data dropped.
  - Then if cont=1: ch=0, {s1,s0}=00, -> SETTLE. Else -> IDLE, and {s1,s0} holds 11 until the next start.
- Handshake:
  - frame and frame_valid stay stable while frame_valid && !frame_ready.
  - frame_valid clears on an accepting edge, unless PUBLISH loads a new frame on that same edge, in which case it stays 1 with the new data.
  - frame_ready while frame_valid=0 has no effect.
- Latency: start sampled on edge k -> frame_valid high after edge k + 4*(SETTLE_CYCLES+1) + 1, i.e. k+13 at the default.
- Continuous frame period is 4*(SETTLE_CYCLES+1)+1 cycles (13 at the default).
- cont dropped mid-scan: the current frame completes and publishes, then IDLE.
- Wrap: ch is a 2-bit counter. It never increments past 3; a new scan reloads 0.

Decomposition:
- Package mux_scan_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, PUBLISH);
  - NUM_CH=4 and the 2-bit channel type;
  - channel-to-select encoding constants CH_A..CH_D.
- One sub-module, mux_scan_timer: a loadable down-counter, SETTLE_CYCLES wide enough for 15, with load/en/done.
- The FSM, shadow register and output register stay in mux_scan_ctrl.

Test Plan:
1. Reset mid-scan: pulse start, assert rst at cycle 5 -> next edge gives s0=s1=0, busy=0, frame_valid=0. A later start gives a clean frame.
2. Single scan, default params, mux model with a=1, b=0, c=1, d=0 and frame_ready=1:
   - select sequence 00,01,10,11, each held 3 cycles;
   - frame=4'b0101 and frame_valid high 13 edges after start, for exactly one cycle.
3. Backpressure: frame_ready=0 and cont=1, inputs changed to a=0, b=1, c=1, d=1 after frame 1:
   - frame stays 4'b0101 with valid=1;
   - second PUBLISH sets overrun=1;
   - clr_ovr clears overrun.
4. Simultaneous accept and publish: cont=1, frame_ready pulsed on the PUBLISH edge -> frame_valid stays 1 and frame updates to the new value (e.g. 4'b1110) with no overrun.
5. Ignored start and mode exit: start pulsed during SETTLE of ch2 has no effect. cont dropped during ch1 -> that frame publishes, then busy=0 and s1s0 hold 11.
6. SETTLE_CYCLES=1: frame_valid 9 edges after start; y toggled one cycle after a select change is still sampled correctly.

Source files
------------

// File: rtl/mux_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared types and constants for the 4:1 mux scan sequencer.
//   state_t  : sequencer states
//   ch_t     : 2-bit channel index, also the {s1,s0} select encoding
//   CH_A..D  : channel -> select encodings
//   TMR_W    : settle timer width (holds up to 15)
// -----------------------------------------------------------------------------
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int TMR_W  = 4;

    typedef logic [1:0] ch_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        SAMPLE  = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    localparam ch_t CH_A = 2'd0;
    localparam ch_t CH_B = 2'd1;
    localparam ch_t CH_C = 2'd2;
    localparam ch_t CH_D = 2'd3;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl_if
// Downstream frame handshake.
//   frame       : published 4-bit frame (bit0=a .. bit3=d)
//   frame_valid : frame holds unconsumed data
//   frame_ready : consumer accepts on an edge where valid && ready
// master = producer (mux_scan_ctrl), slave = consumer.
// -----------------------------------------------------------------------------
interface mux_scan_ctrl_if;

    logic [3:0] frame;
    logic       frame_valid;
    logic       frame_ready;

    modport master (output frame, output frame_valid, input frame_ready);
    modport slave  (input frame, input frame_valid, output frame_ready);

endinterface

// File: rtl/mux_scan_ctrl_timer.sv
// -----------------------------------------------------------------------------
// mux_scan_timer
// Loadable down-counter used to time the settle window.
//   clk, rst : clock, synchronous active-high reset
//   load     : load load_val (wins over en)
//   en       : count down by one, saturating at zero
//   load_val : value loaded on load
//   done     : the current cycle is the last one of the window
// -----------------------------------------------------------------------------
module mux_scan_timer
    import mux_scan_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    // Loaded with N, done is seen while count==1, so the window lasts N cycles.
    assign done = (count <= W'(1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Drives the select lines of an external 4:1 mux round-robin through a,b,c,d,
// waits SETTLE_CYCLES after each select change, samples y, and publishes the
// four samples as one frame over a valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset
//   start    : one-shot scan request, honoured only in IDLE
//   cont     : at frame end, start the next scan immediately
//   s0, s1   : registered mux selects ({s1,s0} = channel)
//   y        : mux output
//   busy     : not IDLE
//   overrun  : sticky, a completed frame was dropped
//   clr_ovr  : clears overrun, wins over a same-cycle set
//   bus      : frame / frame_valid / frame_ready handshake
// -----------------------------------------------------------------------------
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cont,
    output logic                  s0,
    output logic                  s1,
    input  logic                  y,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  clr_ovr,
    mux_scan_ctrl_if.master       bus
);

    state_t            state, state_nxt;
    ch_t               ch, ch_nxt;
    ch_t               sel, sel_nxt;
    logic [NUM_CH-1:0] shadow, shadow_nxt;
    logic [NUM_CH-1:0] frame_q, frame_nxt;
    logic              fv_q, fv_nxt;
    logic              ovr_q, ovr_nxt;
    logic              ovr_set;
    logic              accept;
    logic              tmr_load, tmr_en, tmr_done;

    mux_scan_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (TMR_W'(SETTLE_CYCLES)),
        .done     (tmr_done)
    );

    assign accept = fv_q && bus.frame_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ch      <= CH_A;
            sel     <= CH_A;
            shadow  <= '0;
            frame_q <= '0;
            fv_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            ch      <= ch_nxt;
            sel     <= sel_nxt;
            shadow  <= shadow_nxt;
            frame_q <= frame_nxt;
            fv_q    <= fv_nxt;
            ovr_q   <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ch_nxt     = ch;
        sel_nxt    = sel;
        shadow_nxt = shadow;
        frame_nxt  = frame_q;
        fv_nxt     = fv_q;
        ovr_set    = 1'b0;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;

        // An accept clears valid; a same-edge publish below overrides it.
        if (accept) begin
            fv_nxt = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETTLE;
                    ch_nxt    = CH_A;
                    sel_nxt   = CH_A;
                    tmr_load  = 1'b1;
                end
            end
            SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                shadow_nxt[ch] = y;
                if (ch == CH_D) begin
                    state_nxt = PUBLISH;
                end else begin
                    ch_nxt    = ch_t'(ch + 2'd1);
                    sel_nxt   = ch_t'(ch + 2'd1);
                    state_nxt = SETTLE;
                    tmr_load  = 1'b1;
                end
            end
            PUBLISH: begin
                if (!fv_q || accept) begin
                    frame_nxt = shadow;
                    fv_nxt    = 1'b1;
                end else begin
                    ovr_set = 1'b1;
                end
                if (cont) begin
                    state_nxt = SETTLE;
                    ch_nxt    = CH_A;
                    sel_nxt   = CH_A;
                    tmr_load  = 1'b1;
                end else begin
                    // selects keep pointing at d until the next start
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (clr_ovr) begin
            ovr_nxt = 1'b0;
        end else if (ovr_set) begin
            ovr_nxt = 1'b1;
        end else begin
            ovr_nxt = ovr_q;
        end
    end

    assign s0              = sel[0];
    assign s1              = sel[1];
    assign busy            = (state != IDLE);
    assign overrun         = ovr_q;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = fv_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Two sequencers (SETTLE_CYCLES=2 and =1) share one stimulus stream, each
// driving its own model of the mux. A timing model (cycles since scan start)
// predicts selects, status and frames; published frames go through a
// scoreboard queue popped by a separate monitor.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

    localparam int SC0 = 2;
    localparam int SC1 = 1;

    logic       clk = 1'b0;
    logic       rst, start, cont, ready, clr_ovr;
    logic [3:0] data;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    mux_scan_ctrl_if bus0 ();
    mux_scan_ctrl_if bus1 ();
    assign bus0.frame_ready = ready;
    assign bus1.frame_ready = ready;

    logic s0_0, s1_0, y0, busy0, ovr0;
    logic s0_1, s1_1, y1, busy1, ovr1;
    assign y0 = data[{s1_0, s0_0}];
    assign y1 = data[{s1_1, s0_1}];

    mux_scan_ctrl #(.SETTLE_CYCLES(SC0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .s0(s0_0), .s1(s1_0),
        .y(y0), .busy(busy0), .overrun(ovr0), .clr_ovr(clr_ovr), .bus(bus0)
    );
    mux_scan_ctrl #(.SETTLE_CYCLES(SC1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .s0(s0_1), .s1(s1_1),
        .y(y1), .busy(busy1), .overrun(ovr1), .clr_ovr(clr_ovr), .bus(bus1)
    );

    logic [1:0] d_sel   [2];
    logic       d_busy  [2];
    logic       d_fv    [2];
    logic       d_ovr   [2];
    logic [3:0] d_frame [2];
    assign d_sel[0]   = {s1_0, s0_0};
    assign d_sel[1]   = {s1_1, s0_1};
    assign d_busy[0]  = busy0;
    assign d_busy[1]  = busy1;
    assign d_fv[0]    = bus0.frame_valid;
    assign d_fv[1]    = bus1.frame_valid;
    assign d_ovr[0]   = ovr0;
    assign d_ovr[1]   = ovr1;
    assign d_frame[0] = bus0.frame;
    assign d_frame[1] = bus1.frame;

    // ---------------- reference model ----------------
    logic       m_busy  [2];
    logic       m_fv    [2];
    logic       m_ovr   [2];
    int         m_t     [2];
    logic [3:0] m_bits  [2];
    logic [3:0] m_frame [2];
    logic [1:0] m_sel   [2];
    logic [3:0] exp_q   [2][$];

    function automatic int per_of(input int g);
        return (g == 0) ? SC0 + 1 : SC1 + 1;
    endfunction

    task automatic model_step();
        for (int g = 0; g < 2; g++) begin
            int   p;
            logic acc, fv_before, drop;
            p = per_of(g);
            if (rst) begin
                m_busy[g] = 0; m_fv[g] = 0; m_ovr[g] = 0; m_t[g] = 0;
                m_bits[g] = 0; m_frame[g] = 0; m_sel[g] = 0;
            end else begin
                fv_before = m_fv[g];
                acc       = fv_before && ready;
                drop      = 0;
                if (acc) m_fv[g] = 0;
                if (m_busy[g]) begin
                    m_t[g]++;
                    // channel i is read (i+1) settle periods after scan start
                    for (int i = 0; i < 4; i++)
                        if (m_t[g] == (i + 1) * p) m_bits[g][i] = data[i];
                    if (m_t[g] == 4 * p + 1) begin
                        if (!fv_before || acc) begin
                            m_frame[g] = m_bits[g];
                            m_fv[g]    = 1;
                            exp_q[g].push_back(m_bits[g]);
                        end else begin
                            drop = 1;
                        end
                        if (cont) m_t[g] = 0;
                        else      m_busy[g] = 0;
                    end
                end else if (start) begin
                    m_busy[g] = 1;
                    m_t[g]    = 0;
                end
                if (m_busy[g]) m_sel[g] = (m_t[g] >= 3 * p) ? 2'd3 : 2'(m_t[g] / p);
                if (clr_ovr)   m_ovr[g] = 0;
                else if (drop) m_ovr[g] = 1;
            end
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            m_busy[g] = 0; m_fv[g] = 0; m_ovr[g] = 0; m_t[g] = 0;
            m_bits[g] = 0; m_frame[g] = 0; m_sel[g] = 0;
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic check(input string name, input int g, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cfg%0d got=%0h expected=%0h at %0t", name, g, act, exp, $time);
        end
    endtask

    initial begin
        logic fv_pre  [2];
        logic acc_pre [2];
        logic [3:0] e;
        forever begin
            @(posedge clk);
            for (int g = 0; g < 2; g++) begin
                fv_pre[g]  = d_fv[g];
                acc_pre[g] = d_fv[g] && ready;
            end
            #1;
            for (int g = 0; g < 2; g++) begin
                check("sel",     g, 32'(d_sel[g]),   32'(m_sel[g]));
                check("busy",    g, 32'(d_busy[g]),  32'(m_busy[g]));
                check("valid",   g, 32'(d_fv[g]),    32'(m_fv[g]));
                check("overrun", g, 32'(d_ovr[g]),   32'(m_ovr[g]));
                // a new frame is presented when valid rises or is reloaded on an accept
                if (d_fv[g] === 1'b1 && (!fv_pre[g] || acc_pre[g])) begin
                    if (exp_q[g].size() == 0) begin
                        check("unexpected_frame", g, 32'(d_frame[g]), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q[g].pop_front();
                        check("frame", g, 32'(d_frame[g]), 32'(e));
                    end
                end else begin
                    check("frame_hold", g, 32'(d_frame[g]), 32'(m_frame[g]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1; start = 0; cont = 0; ready = 1; clr_ovr = 0; data = 4'b0000;
        cyc(3);
        rst = 0;

        // mid-scan reset, then a clean scan
        cyc(2); data = 4'b1011; start = 1;
        cyc(1); start = 0;
        cyc(4); rst = 1;
        cyc(1); rst = 0;
        cyc(2); start = 1;
        cyc(1); start = 0;
        cyc(16);

        // single scan a=1 b=0 c=1 d=0
        data = 4'b0101; ready = 1; start = 1;
        cyc(1); start = 0;
        cyc(16);

        // backpressure, overrun, clear, then accept coinciding with publish
        ready = 0; cont = 1; data = 4'b0101; start = 1;
        cyc(1);  start = 0;
        cyc(13); data = 4'b1110;
        cyc(13); clr_ovr = 1;
        cyc(1);  clr_ovr = 0;
        cyc(12); clr_ovr = 1;
        cyc(1);  clr_ovr = 0;
        cyc(11); ready = 1;
        cyc(1);  cont = 0;
        cyc(20);

        // start ignored during settle, cont dropped mid-scan
        data = 4'b1001; ready = 1; cont = 1; start = 1;
        cyc(1); start = 0;
        cyc(3); cont = 0;
        cyc(3); start = 1;
        cyc(1); start = 0;
        cyc(20);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(1);
            rst     = ($urandom_range(0, 199) == 0);
            start   = ($urandom_range(0, 7) == 0);
            cont    = ($urandom_range(0, 3) == 0);
            ready   = 1'($urandom_range(0, 1));
            clr_ovr = ($urandom_range(0, 15) == 0);
            data    = 4'($urandom);
        end
        cyc(1);
        rst = 0; start = 0; cont = 0; ready = 1; clr_ovr = 0;
        cyc(40);

        for (int g = 0; g < 2; g++)
            check("scoreboard_drained", g, 32'(exp_q[g].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
